// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two requesters one-cycle access to a single-port
// data memory, with address bounds checking and registered read-data return.
module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic [WIDTH-1:0] rdata0,
  output logic             done0,
  output logic             err0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic [WIDTH-1:0] rdata1,
  output logic             done1,
  output logic             err1,
  output logic [WIDTH-1:0] mem_A,
  output logic [WIDTH-1:0] mem_WD,
  output logic             mem_WE,
  input  logic [WIDTH-1:0] mem_RD,
  output logic             busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_last;
  logic             r_sel;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;

  logic [WIDTH-1:0] r_rdata0;
  logic [WIDTH-1:0] r_rdata1;
  logic             r_done0;
  logic             r_done1;
  logic             r_err0;
  logic             r_err1;

  logic             w_eff0;
  logic             w_eff1;
  logic             w_grant;
  logic             w_win_sel;
  logic             w_in_range;
  logic [WIDTH-1:0] w_mem_a;
  logic [WIDTH-1:0] w_mem_wd;
  logic             w_mem_we;

  // A requester whose done pulse is still showing is not eligible, so a held
  // request is never served twice for the same transaction.
  assign w_eff0     = req0 & ~r_done0;
  assign w_eff1     = req1 & ~r_done1;
  assign w_in_range = (r_addr < DEPTH_W);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration, next state and memory pin drive
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win_sel   = 1'b0;
    w_mem_a     = {WIDTH{1'b0}};
    w_mem_wd    = {WIDTH{1'b0}};
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_eff0 && w_eff1) begin
          w_grant   = 1'b1;
          w_win_sel = ~r_last;
        end else if (w_eff0) begin
          w_grant   = 1'b1;
          w_win_sel = 1'b0;
        end else if (w_eff1) begin
          w_grant   = 1'b1;
          w_win_sel = 1'b1;
        end else begin
          w_grant   = 1'b0;
          w_win_sel = 1'b0;
        end
        if (w_grant) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        w_mem_a     = r_addr;
        w_mem_wd    = r_wdata;
        w_mem_we    = r_we & w_in_range;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch the winning request so later input changes cannot disturb the access
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= {WIDTH{1'b0}};
      r_wdata <= {WIDTH{1'b0}};
    end else if (w_grant) begin
      r_sel   <= w_win_sel;
      r_we    <= w_win_sel ? we1    : we0;
      r_addr  <= w_win_sel ? addr1  : addr0;
      r_wdata <= w_win_sel ? wdata1 : wdata0;
    end else begin
      r_sel   <= r_sel;
      r_we    <= r_we;
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
    end
  end

  // Completion: one-cycle done/err pulses, read data held until next service
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last   <= 1'b1;
      r_rdata0 <= {WIDTH{1'b0}};
      r_rdata1 <= {WIDTH{1'b0}};
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      if (r_state == S_ACCESS) begin
        r_last <= r_sel;
        if (r_sel) begin
          r_rdata1 <= w_in_range ? mem_RD : {WIDTH{1'b0}};
          r_done1  <= 1'b1;
          r_err1   <= ~w_in_range;
        end else begin
          r_rdata0 <= w_in_range ? mem_RD : {WIDTH{1'b0}};
          r_done0  <= 1'b1;
          r_err0   <= ~w_in_range;
        end
      end else begin
        r_last <= r_last;
      end
    end
  end

  assign mem_A  = w_mem_a;
  assign mem_WD = w_mem_wd;
  // Reset aborts an in-flight write immediately, not at the next edge.
  assign mem_WE = w_mem_we & ~RST;
  assign busy   = (r_state == S_ACCESS);

  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign err0   = r_err0;
  assign err1   = r_err1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level memory/arbitration model.
module tb_dmem_arbiter;

  localparam int W = 32;
  localparam int D = 100;

  logic         CLK = 1'b0;
  logic         RST;
  logic         req0, we0, req1, we1;
  logic [W-1:0] addr0, wdata0, addr1, wdata1;
  logic [W-1:0] rdata0, rdata1;
  logic         done0, err0, done1, err1;
  logic [W-1:0] mem_A, mem_WD, mem_RD;
  logic         mem_WE, busy;

  logic [W-1:0] tb_mem  [0:D-1];
  logic [W-1:0] ref_mem [0:D-1];
  logic         tb_init;
  logic         last_model;
  logic [W-1:0] last_rd [0:1];
  int           checks   = 0;
  int           failures = 0;

  dmem_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0), .done0(done0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(rdata1), .done1(done1), .err1(err1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] pat(input int i);
    return 32'(i) * 32'h0101_0101 + 32'h0F0F_0000;
  endfunction

  // Memory model; an out-of-range address returns a recognisable junk word
  assign mem_RD = (mem_A < 32'(D)) ? tb_mem[mem_A[6:0]] : 32'hBAD0_BAD0;

  always @(posedge CLK) begin
    if (tb_init) begin
      for (int i = 0; i < D; i++) tb_mem[i] <= pat(i);
    end else if (mem_WE && (mem_A < 32'(D))) begin
      tb_mem[mem_A[6:0]] <= mem_WD;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction per selected requester, issued together; the model
  // decides service order, expected latency, data, error and memory update.
  task automatic run_txn(input bit u0, input bit u1,
                         input logic w0, input logic [W-1:0] a0, input logic [W-1:0] d0,
                         input logic w1, input logic [W-1:0] a1, input logic [W-1:0] d1,
                         output logic [W-1:0] first_wr_addr);
    bit           u [2];
    logic         ww [2];
    logic [W-1:0] aa [2];
    logic [W-1:0] dd [2];
    int           exp_t [2];
    int           got_t [2];
    int           ndone [2];
    logic [W-1:0] exp_rd [2];
    logic         exp_err [2];
    int           order [2];
    int           exp_wr;
    int           nwr;
    u[0] = u0; u[1] = u1; ww[0] = w0; ww[1] = w1;
    aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
    exp_t[0] = 0; exp_t[1] = 0; got_t[0] = 0; got_t[1] = 0;
    ndone[0] = 0; ndone[1] = 0; exp_wr = 0; nwr = 0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    first_wr_addr = 32'hFFFF_FFFF;
    if (u0 && u1) order[0] = last_model ? 0 : 1;
    else          order[0] = u0 ? 0 : 1;
    order[1] = 1 - order[0];
    for (int n = 0; n < 2; n++) begin
      int k;
      k = order[n];
      if (u[k]) begin
        exp_t[k] = (n == 0) ? 2 : 4;
        if (aa[k] < 32'(D)) begin
          exp_rd[k]  = ref_mem[aa[k][6:0]];
          exp_err[k] = 1'b0;
          if (ww[k]) begin
            ref_mem[aa[k][6:0]] = dd[k];
            exp_wr++;
          end
        end else begin
          exp_rd[k]  = '0;
          exp_err[k] = 1'b1;
        end
        last_model = k[0];
        last_rd[k] = exp_rd[k];
      end
    end
    req0 = u0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = u1; we1 = w1; addr1 = a1; wdata1 = d1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (mem_WE) begin
        if (nwr == 0) first_wr_addr = mem_A;
        nwr++;
      end
      if (done0) begin
        ndone[0]++;
        if (got_t[0] == 0) got_t[0] = t;
        if (u[0]) begin
          chk("rdata0", rdata0, exp_rd[0]);
          chk("err0", 32'(err0), 32'(exp_err[0]));
        end
        req0 = 1'b0;
      end
      if (done1) begin
        ndone[1]++;
        if (got_t[1] == 0) got_t[1] = t;
        if (u[1]) begin
          chk("rdata1", rdata1, exp_rd[1]);
          chk("err1", 32'(err1), 32'(exp_err[1]));
        end
        req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("done0_cycle", 32'(got_t[0]), 32'(exp_t[0]));
    chk("done1_cycle", 32'(got_t[1]), 32'(exp_t[1]));
    chk("done0_count", 32'(ndone[0]), 32'(u0 ? 1 : 0));
    chk("done1_count", 32'(ndone[1]), 32'(u1 ? 1 : 0));
    chk("write_count", 32'(nwr), 32'(exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] wa;
    int           wecnt;
    RST = 1'b1; tb_init = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < D; i++) ref_mem[i] = pat(i);
    last_model = 1'b1; last_rd[0] = '0; last_rd[1] = '0;
    tick(); tick();
    RST = 1'b0; tb_init = 1'b0;

    // Reset state
    chk("reset_rdata0", rdata0, '0);
    chk("reset_rdata1", rdata1, '0);
    chk("reset_flags", 32'({busy, mem_WE, done0, done1, err0, err1}), 32'h0);

    // Write 5 via requester 0, read it back via requester 1
    run_txn(1'b1, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, wa);
    chk("write_addr_5", wa, 32'd5);
    run_txn(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 32'd5, '0, wa);
    chk("readback_5", rdata1, 32'hDEAD_BEEF);

    // Both held from reset: strict alternation starting with requester 0
    RST = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
    tick();
    RST = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("alt_done0", 32'(done0), 32'((t % 4) == 2));
      chk("alt_done1", 32'(done1), 32'((t % 4) == 0));
      if ((t % 4) == 2) chk("alt_rdata0", rdata0, ref_mem[1]);
      if ((t % 4) == 0) begin
        chk("alt_rdata1", rdata1, ref_mem[2]);
        chk("rdata0_hold", rdata0, ref_mem[1]);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    last_model = 1'b1; last_rd[0] = ref_mem[1]; last_rd[1] = ref_mem[2];
    tick(); tick();

    // Out-of-range boundary then last valid word
    run_txn(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 32'd100, 32'hCAFE_0100, wa);
    run_txn(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 32'd99, 32'hCAFE_0099, wa);
    chk("write_addr_99", wa, 32'd99);
    run_txn(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, '0, 1'b0, '0, '0, wa);

    // Reset in the ACCESS cycle aborts the write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h0000_1234;
    tick();
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_we_before_rst", 32'(mem_WE), 32'd1);
    RST = 1'b1;
    #1;
    chk("abort_we_in_rst", 32'(mem_WE), 32'd0);
    tick();
    RST = 1'b0; req0 = 1'b0;
    last_model = 1'b1; last_rd[0] = '0; last_rd[1] = '0;
    wecnt = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("abort_no_done0", 32'(done0), 32'd0);
      if (mem_WE) wecnt++;
    end
    chk("abort_no_write", 32'(wecnt), 32'd0);
    run_txn(1'b1, 1'b0, 1'b0, 32'd7, '0, 1'b0, '0, '0, wa);
    chk("abort_prior_7", rdata0, pat(7));

    // Requester 0 held across its done with a new transaction
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd12; wdata0 = 32'h5A5A_1212;
    tick(); tick();
    chk("held_done_first", 32'(done0), 32'd1);
    chk("held_rdata_first", rdata0, ref_mem[12]);
    ref_mem[12] = 32'h5A5A_1212;
    we0 = 1'b0;
    tick();
    chk("held_masked", 32'({done0, busy}), 32'h0);
    tick();
    chk("held_access", 32'({done0, busy}), 32'h1);
    tick();
    chk("held_done_second", 32'(done0), 32'd1);
    chk("held_rdata_second", rdata0, 32'h5A5A_1212);
    req0 = 1'b0;
    last_model = 1'b0; last_rd[0] = 32'h5A5A_1212;
    tick();

    // Randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      int           mode;
      logic [W-1:0] ra [2];
      logic [W-1:0] rdat [2];
      logic         rw [2];
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) == 0) ra[k] = 32'($urandom_range(98, 101));
        else                          ra[k] = 32'($urandom_range(0, 104));
        rdat[k] = $urandom;
        rw[k]   = 1'($urandom_range(0, 1));
      end
      run_txn(mode != 1, mode != 0, rw[0], ra[0], rdat[0], rw[1], ra[1], rdat[1], wa);
    end

    // Idle: nothing moves, read data held
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("idle_flags", 32'({busy, mem_WE, done0, done1, err0, err1}), 32'h0);
      chk("idle_mem_A", mem_A, '0);
    end
    chk("idle_rdata0_hold", rdata0, last_rd[0]);
    chk("idle_rdata1_hold", rdata1, last_rd[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
